// File: rtl/wb_init_pkg.sv
// Shared types for the Wishbone SDRAM initiator: FSM states, default bus widths
// and the latched-command record.
package wb_init_pkg;

  localparam int WB_AW = 24;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } wb_init_state_e;

  typedef struct packed {
    logic                   we;
    logic [WB_AW-1:0]       adr;
    logic [WB_DW-1:0]       dat;
    logic [(WB_DW/8)-1:0]   sel;
  } wb_cmd_t;

endpackage

// File: rtl/wb_init_timeout.sv
// REQ-phase watchdog: counts stalled strobe cycles and flags the terminal count.
// Instantiated only when WB_INIT_TIMEOUT_EN is defined.
module wb_init_timeout #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Stall counter, cleared when a new command enters REQ.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == TC);

endmodule

// File: rtl/wb_sdram_initiator.sv
// Wishbone classic initiator: one bus cycle per valid/ready command, result on a
// valid/ready response channel. Define WB_INIT_TIMEOUT_EN to abort stalled cycles.
module wb_sdram_initiator
  import wb_init_pkg::*;
#(
  parameter int AW          = WB_AW,
  parameter int DW          = WB_DW,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_we_o,
  output logic            rsp_err_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  output logic            busy_o
);

  wb_init_state_e r_state, w_state_nxt;
  logic           w_accept;
  logic           w_ack;
  logic           w_abort;

  // Gated by reset so every output reads 0 while rst_i is low.
  assign cmd_ready_o = rst_i & (r_state == IDLE);
  assign w_accept    = cmd_valid_i & cmd_ready_o;
  assign w_ack       = wb_ack_i & (r_state == REQ);

`ifdef WB_INIT_TIMEOUT_EN
  logic w_tc;

  wb_init_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_clr   (w_accept),
    .i_inc   ((r_state == REQ) & ~wb_ack_i),
    .o_tc    (w_tc)
  );

  // Ack on the terminal-count cycle takes priority over the abort.
  assign w_abort = w_tc & (r_state == REQ) & ~wb_ack_i;
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = REQ;
        else          w_state_nxt = IDLE;
      end
      REQ: begin
        if (w_ack || w_abort) w_state_nxt = RSP;
        else                  w_state_nxt = REQ;
      end
      RSP: begin
        if (rsp_ready_i) w_state_nxt = IDLE;
        else             w_state_nxt = RSP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered bus and response outputs; adr/dat/sel persist after the cycle ends.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_we_o    <= 1'b0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      busy_o <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cmd_we_i;
            wb_adr_o <= cmd_adr_i;
            wb_dat_o <= cmd_dat_i;
            wb_sel_o <= cmd_sel_i;
          end
        end
        REQ: begin
          if (w_ack || w_abort) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= wb_we_o;
            rsp_err_o   <= w_abort;
            rsp_dat_o   <= (w_ack && !wb_we_o) ? wb_dat_i : '0;
          end
        end
        RSP: begin
          if (rsp_ready_i) rsp_valid_o <= 1'b0;
        end
        default: begin
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sdram_initiator.sv
// Self-checking bench for wb_sdram_initiator: directed scenarios plus randomized
// traffic against a byte-masked memory model.
module tb_wb_sdram_initiator;
  import wb_init_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [23:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_we_o;
  logic        rsp_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [23:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        busy_o;

  wb_sdram_initiator #(.AW(24), .DW(32), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_we_o(rsp_we_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference memory (updated from commands) and slave memory (updated from the bus).
  logic [31:0] mmem [16];
  logic [31:0] smem [16];

  // Observations recorded by run_txn.
  int          o_nstb, o_nunst, o_nhold_bad;
  logic        o_valid, o_we, o_err;
  logic [31:0] o_dat;
  logic        o_after_valid, o_after_busy, o_after_ready, o_after_cyc;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one command, act as a slave acking in stb cycle ack_at (0 = never),
  // then hold the response for 'hold' cycles before consuming it.
  task automatic run_txn(input wb_cmd_t c, input int ack_at, input int hold, input logic pend);
    int guard;
    cmd_valid_i = 1'b1;
    cmd_we_i = c.we; cmd_adr_i = c.adr; cmd_dat_i = c.dat; cmd_sel_i = c.sel;
    step();
    cmd_valid_i = 1'b0;
    cmd_dat_i = $urandom; cmd_adr_i = 24'($urandom);
    o_nstb = 0; o_nunst = 0; guard = 0;
    while (wb_stb_o && guard < 64) begin
      o_nstb++;
      if (!wb_cyc_o || wb_we_o !== c.we || wb_adr_o !== c.adr || wb_sel_o !== c.sel ||
          (c.we && wb_dat_o !== c.dat) || rsp_valid_o || cmd_ready_o || !busy_o)
        o_nunst++;
      if (o_nstb == ack_at) begin
        wb_ack_i = 1'b1;
        if (wb_we_o) smem[wb_adr_o[3:0]] = merge(smem[wb_adr_o[3:0]], wb_dat_o, wb_sel_o);
        wb_dat_i = smem[wb_adr_o[3:0]];
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
      end
      step();
      wb_ack_i = 1'b0;
      guard++;
    end
    o_valid = rsp_valid_o; o_dat = rsp_dat_o; o_we = rsp_we_o; o_err = rsp_err_o;
    o_nhold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (pend) begin
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 24'h00000F;
      end
      wb_ack_i = (i % 2 == 0);
      step();
      wb_ack_i = 1'b0;
      if (rsp_valid_o !== o_valid || rsp_dat_o !== o_dat || rsp_we_o !== o_we ||
          rsp_err_o !== o_err || cmd_ready_o !== 1'b0 || wb_cyc_o !== 1'b0)
        o_nhold_bad++;
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b0;
    o_after_valid = rsp_valid_o; o_after_busy = busy_o;
    o_after_ready = cmd_ready_o; o_after_cyc = wb_cyc_o;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if ({cmd_ready_o, rsp_valid_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000000",
                      {cmd_ready_o, rsp_valid_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o});
    end
    total++; if ({wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat_o, rsp_we_o, rsp_err_o} !== '0) begin
      bad++; $display("FAIL reset_data got adr=%h dat=%h rsp=%h exp=0", wb_adr_o, wb_dat_o, rsp_dat_o);
    end
    rst_i = 1'b1;
    step();
    total++; if (cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready_o);
    end
  endtask

  task automatic test_write();
    wb_cmd_t c;
    c = '{we: 1'b1, adr: 24'h000010, dat: 32'hDEADBEEF, sel: 4'hF};
    run_txn(c, 3, 0, 1'b0);
    mmem[0] = merge(mmem[0], c.dat, c.sel);
    total++; if (o_nstb !== 3) begin bad++; $display("FAIL wr_stb_cycles got=%0d exp=3", o_nstb); end
    total++; if (o_nunst !== 0) begin bad++; $display("FAIL wr_bus_stable got=%0d exp=0", o_nunst); end
    total++; if ({o_valid, o_we, o_err} !== 3'b110 || o_dat !== 32'h0) begin
      bad++; $display("FAIL wr_rsp got v/we/err=%b dat=%h exp=110 dat=0", {o_valid, o_we, o_err}, o_dat);
    end
    total++; if ({o_after_valid, o_after_busy, o_after_ready} !== 3'b001) begin
      bad++; $display("FAIL wr_done got=%b exp=001", {o_after_valid, o_after_busy, o_after_ready});
    end
    total++; if (smem[0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_slave_mem got=%h exp=deadbeef", smem[0]);
    end
  endtask

  task automatic test_read();
    wb_cmd_t c;
    smem[4] = 32'h12345678; mmem[4] = 32'h12345678;
    c = '{we: 1'b0, adr: 24'h0000A4, dat: 32'h0, sel: 4'hF};
    run_txn(c, 1, 0, 1'b0);
    total++; if (o_nstb !== 1) begin bad++; $display("FAIL rd_stb_cycles got=%0d exp=1", o_nstb); end
    total++; if ({o_valid, o_we, o_err} !== 3'b100 || o_dat !== 32'h12345678) begin
      bad++; $display("FAIL rd_rsp got v/we/err=%b dat=%h exp=100 dat=12345678", {o_valid, o_we, o_err}, o_dat);
    end
  endtask

  task automatic test_backpressure();
    wb_cmd_t c;
    c = '{we: 1'b0, adr: 24'h000010, dat: 32'h0, sel: 4'hF};
    run_txn(c, 2, 5, 1'b1);
    total++; if (o_nhold_bad !== 0) begin bad++; $display("FAIL bp_hold_stable got=%0d exp=0", o_nhold_bad); end
    total++; if (o_dat !== mmem[0] || o_valid !== 1'b1) begin
      bad++; $display("FAIL bp_rsp got v=%b dat=%h exp v=1 dat=%h", o_valid, o_dat, mmem[0]);
    end
    total++; if ({o_after_cyc, o_after_valid, o_after_ready} !== 3'b001) begin
      bad++; $display("FAIL bp_no_early_accept got=%b exp=001", {o_after_cyc, o_after_valid, o_after_ready});
    end
  endtask

  task automatic test_spurious_ack();
    wb_cmd_t c;
    int extra;
    wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0BAD0;
    step();
    wb_ack_i = 1'b0;
    step();
    total++; if ({rsp_valid_o, busy_o, wb_cyc_o} !== 3'b000) begin
      bad++; $display("FAIL spur_idle got=%b exp=000", {rsp_valid_o, busy_o, wb_cyc_o});
    end
    c = '{we: 1'b0, adr: 24'h000004, dat: 32'h0, sel: 4'hF};
    run_txn(c, 2, 1, 1'b0);
    extra = 0;
    for (int i = 0; i < 4; i++) begin step(); if (rsp_valid_o) extra++; end
    total++; if (o_valid !== 1'b1 || o_dat !== mmem[4] || extra !== 0) begin
      bad++; $display("FAIL spur_one_rsp got v=%b dat=%h extra=%0d exp v=1 dat=%h extra=0",
                      o_valid, o_dat, extra, mmem[4]);
    end
  endtask

  task automatic test_async_reset();
    int stale;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 24'h000001;
    step();
    cmd_valid_i = 1'b0;
    step();
    total++; if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin
      bad++; $display("FAIL ar_pre got=%b exp=11", {wb_cyc_o, wb_stb_o});
    end
    #2 rst_i = 1'b0;
    #1;
    total++; if ({wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o, cmd_ready_o} !== 5'b0) begin
      bad++; $display("FAIL ar_async got=%b exp=00000", {wb_cyc_o, wb_stb_o, rsp_valid_o, busy_o, cmd_ready_o});
    end
    step(); step();
    rst_i = 1'b1;
    step();
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      wb_ack_i = 1'b1; step(); wb_ack_i = 1'b0;
      if (rsp_valid_o || wb_cyc_o || !cmd_ready_o) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL ar_no_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_timeout();
    wb_cmd_t c;
    smem[7] = 32'hCAFEF00D; mmem[7] = 32'hCAFEF00D;
    c = '{we: 1'b0, adr: 24'h000007, dat: 32'h0, sel: 4'hF};
`ifdef WB_INIT_TIMEOUT_EN
    run_txn(c, 0, 0, 1'b0);
    total++; if (o_nstb !== 8) begin bad++; $display("FAIL to_stb_cycles got=%0d exp=8", o_nstb); end
    total++; if ({o_valid, o_err} !== 2'b11 || o_dat !== 32'h0) begin
      bad++; $display("FAIL to_err_rsp got v/err=%b dat=%h exp=11 dat=0", {o_valid, o_err}, o_dat);
    end
    run_txn(c, 8, 0, 1'b0);
    total++; if (o_nstb !== 8 || o_err !== 1'b0 || o_dat !== mmem[7]) begin
      bad++; $display("FAIL to_ack_wins got stb=%0d err=%b dat=%h exp 8 0 %h", o_nstb, o_err, o_dat, mmem[7]);
    end
`else
    run_txn(c, 20, 0, 1'b0);
    total++; if (o_nstb !== 20 || o_err !== 1'b0 || o_dat !== mmem[7]) begin
      bad++; $display("FAIL no_to_wait got stb=%0d err=%b dat=%h exp 20 0 %h", o_nstb, o_err, o_dat, mmem[7]);
    end
`endif
  endtask

  task automatic test_random();
    wb_cmd_t c;
    int ack_at, errs;
    logic [31:0] exp_dat;
    errs = 0;
    for (int n = 0; n < 24; n++) begin
      c.we = 1'($urandom); c.adr = 24'($urandom); c.dat = $urandom; c.sel = 4'($urandom);
      ack_at = $urandom_range(1, 4);
      exp_dat = c.we ? 32'h0 : mmem[c.adr[3:0]];
      run_txn(c, ack_at, $urandom_range(0, 3), 1'($urandom));
      if (c.we) mmem[c.adr[3:0]] = merge(mmem[c.adr[3:0]], c.dat, c.sel);
      total++; if (o_nstb !== ack_at || o_nunst !== 0 || o_nhold_bad !== 0 ||
                   {o_valid, o_we, o_err} !== {1'b1, c.we, 1'b0} || o_dat !== exp_dat ||
                   {o_after_valid, o_after_busy, o_after_ready} !== 3'b001) begin
        bad++; errs++;
        $display("FAIL rand_txn%0d got stb=%0d unst=%0d we=%b dat=%h exp stb=%0d we=%b dat=%h",
                 n, o_nstb, o_nunst, o_we, o_dat, ack_at, c.we, exp_dat);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mmem[i] = 32'h0; smem[i] = 32'h0; end
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_spurious_ack();
    test_async_reset();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sdram_initiator.md
Name: wb_sdram_initiator

Overview:
Wishbone classic initiator that drives the SDRAM controller's slave port (cyc/stb/ack). It accepts single read/write commands on a valid/ready command channel and runs one Wishbone cycle per command. It returns the ack'd read data, or a write completion, on a valid/ready response channel. It sits between test/DSP datapath logic and the SDRAM controller and acts as the RTL counterpart of the slave-side protocol checks.

Parameters:
AW, 24, Wishbone address width
DW, 32, Wishbone data width; must be a multiple of 8
TIMEOUT_CYC, 256, max cycles stb held without ack before abort (used only with the optional feature)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_adr_i  in  AW  word address
cmd_dat_i  in  DW  write data
cmd_sel_i  in  DW/8  byte selects
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_dat_o  out  DW  read data (0 for writes)
rsp_we_o  out  1  echo of command we
rsp_err_o  out  1  1=cycle aborted by timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  AW  Wishbone address
wb_dat_o  out  DW  Wishbone write data
wb_sel_o  out  DW/8  Wishbone byte selects
wb_dat_i  in  DW  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock clk_i; reset rst_i is asynchronous, active-low.
- Reset asserted (rst_i=0) forces all outputs to 0 immediately, state to IDLE, and timeout counter to 0. This applies mid-cycle as well: cyc/stb drop asynchronously and no response is produced for the aborted command.
- All outputs are registered except cmd_ready_o, which is decoded from state.
- FSM states:
  - IDLE: cmd_ready_o=1. On valid&ready, latch we/adr/dat/sel into wb_* registers and go to REQ. cyc_o and stb_o are high from the next cycle.
  - REQ: cyc_o=stb_o=1 and wb_* held stable. When wb_ack_i=1 is sampled: clear cyc/stb at that edge, capture wb_dat_i into rsp_dat_o for reads (0 for writes), set rsp_we_o, set rsp_valid_o=1, rsp_err_o=0, and go to RSP.
  - RSP: rsp_* held stable until rsp_ready_i=1, then rsp_valid_o=0 and go to IDLE. cmd_ready_o=0 in RSP, so there are no back-to-back cycles.
- Latency:
  - Command accept edge N gives cyc/stb high in cycle N+1.
  - Ack sampled at edge M gives rsp_valid in cycle M+1.
  - Zero-wait-state ack gives exactly one stb cycle.
- wb_ack_i while cyc_o=0 (IDLE/RSP) is ignored.
- cmd_valid_i while busy is not accepted; the command-side master holds it.
- wb_dat_o/wb_adr_o keep their last value after a cycle ends; only cyc/stb/we are cleared (we_o cleared with cyc).

Optional Feature:
Macro WB_INIT_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYC)-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 with no ack, cyc/stb drop, rsp_err_o=1, rsp_dat_o=0, and the FSM goes to RSP.
  - Ack in the same cycle as the terminal count wins: normal response, err=0.
- Undefined: no counter is built, REQ waits indefinitely, and rsp_err_o is tied 0.

Decomposition:
- Package wb_init_pkg holds:
  - state enum wb_init_state_e {IDLE, REQ, RSP}
  - default AW/DW localparams
  - a packed struct wb_cmd_t {we, adr, dat, sel} used for the latched command
- One natural sub-module: wb_init_timeout (counter plus terminal-count flag), instantiated only under WB_INIT_TIMEOUT_EN.

Test Plan:
1. Write adr=0x000010, dat=0xDEADBEEF, sel=0xF, ack after 3 cycles -> cyc/stb high exactly 3 cycles with we_o=1 and stable adr/dat; rsp_valid with rsp_we=1, rsp_dat=0, err=0.
2. Read adr=0x0000A4, slave acks same cycle stb rises, wb_dat_i=0x12345678 -> one stb cycle; rsp_dat=0x12345678, rsp_we=0.
3. Response backpressure: hold rsp_ready_i=0 for 5 cycles after read -> rsp_* stable, cmd_ready_o=0 throughout, new cmd_valid not accepted until the cycle after rsp handshake.
4. Spurious wb_ack_i pulse in IDLE, then a read -> no response from the pulse; exactly one response for the read.
5. Drive rst_i=0 mid-REQ (cycle 2 of stb) -> cyc/stb/rsp_valid go 0 without waiting for a clock edge; after release, cmd_ready_o=1 and no stale response appears.
6. With WB_INIT_TIMEOUT_EN and TIMEOUT_CYC=8, never ack -> stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0; a repeat run with ack on the 8th cycle gives err=0 and valid data.
